// File: rtl/bfp_shifter.sv
// rtl/bfp_shifter.sv - block-floating-point normalizer: per-stage rounding right shift and block exponent
// One common shift is latched at each stage boundary and applied, rounded half toward +inf, to every sample.
module bfp_shifter #(
   parameter int FFT_DW    = 16,
   parameter int FFT_BFPDW = 5,
   parameter int FFT_TGTBW = 15,
   parameter int FFT_EXPDW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_exp,
   input  logic                 bfp_load,
   input  logic [FFT_BFPDW-1:0] max_bw,
   input  logic                 din_valid,
   input  logic [FFT_DW-1:0]    din_re,
   input  logic [FFT_DW-1:0]    din_im,
   output logic                 dout_valid,
   output logic [FFT_DW-1:0]    dout_re,
   output logic [FFT_DW-1:0]    dout_im,
   output logic [FFT_BFPDW-1:0] shift,
   output logic [FFT_EXPDW-1:0] bfp_exp
);
   localparam int SUMW = ((FFT_EXPDW > FFT_BFPDW) ? FFT_EXPDW : FFT_BFPDW) + 1;
   localparam logic [SUMW-1:0]   EXP_MAX = SUMW'((1 << FFT_EXPDW) - 1);
   localparam logic [FFT_DW-1:0] POS_MAX = {1'b0, {(FFT_DW-1){1'b1}}};

   logic [31:0]          excess;
   logic [FFT_BFPDW-1:0] s_new;
   logic [SUMW-1:0]      exp_base;
   logic [SUMW-1:0]      exp_sum;

   logic                 s1_valid;
   logic [FFT_DW-1:0]    s1_q_re;
   logic [FFT_DW-1:0]    s1_q_im;
   logic                 s1_rb_re;
   logic                 s1_rb_im;

   // Bit just below the retained LSB; a zero shift has no discarded bits.
   function automatic logic round_bit(input logic [FFT_DW-1:0] d, input logic [FFT_BFPDW-1:0] s);
      return (s != '0) && (((d >> (s - 1'b1)) & FFT_DW'(1)) != '0);
   endfunction

   always_comb begin
      excess = 32'd0;
      if (32'(max_bw) > 32'(FFT_TGTBW)) begin
         excess = 32'(max_bw) - 32'(FFT_TGTBW);
      end
      if (excess > 32'(FFT_DW - 1)) begin
         excess = 32'(FFT_DW - 1);
      end
      s_new    = FFT_BFPDW'(excess);
      exp_base = clr_exp ? '0 : SUMW'(bfp_exp);
      exp_sum  = exp_base + SUMW'(s_new);
   end

   // A load in the same cycle as a clear starts the new frame with this stage's shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift   <= '0;
         bfp_exp <= '0;
      end else if (bfp_load) begin
         shift   <= s_new;
         bfp_exp <= (exp_sum > EXP_MAX) ? EXP_MAX[FFT_EXPDW-1:0] : exp_sum[FFT_EXPDW-1:0];
      end else if (clr_exp) begin
         shift   <= '0;
         bfp_exp <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_q_re  <= '0;
         s1_q_im  <= '0;
         s1_rb_re <= 1'b0;
         s1_rb_im <= 1'b0;
      end else begin
         s1_valid <= din_valid;
         if (din_valid) begin
            s1_q_re  <= $signed(din_re) >>> shift;
            s1_q_im  <= $signed(din_im) >>> shift;
            s1_rb_re <= round_bit(din_re, shift);
            s1_rb_im <= round_bit(din_im, shift);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_valid <= 1'b0;
         dout_re    <= '0;
         dout_im    <= '0;
      end else begin
         dout_valid <= s1_valid;
         if (s1_valid) begin
            dout_re <= s1_q_re + FFT_DW'(s1_rb_re);
            dout_im <= s1_q_im + FFT_DW'(s1_rb_im);
         end
      end
   end

   // With s>=1 the quotient never reaches the positive maximum, so the round-up cannot wrap.
   always @(posedge clk) begin
      if (rst && s1_valid) begin
         assert (!(s1_rb_re && (s1_q_re == POS_MAX)));
         assert (!(s1_rb_im && (s1_q_im == POS_MAX)));
      end
   end

endmodule

// File: tb/tb_bfp_shifter.sv
// tb/tb_bfp_shifter.sv - randomized self-checking bench for bfp_shifter against an arithmetic model
// Three instances (default, 3-bit exponent, zero target width) share one stimulus stream.
module tb_bfp_shifter;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr_exp = 1'b0;
   logic        bfp_load = 1'b0;
   logic [4:0]  max_bw = '0;
   logic        din_valid = 1'b0;
   logic [15:0] din_re = '0;
   logic [15:0] din_im = '0;

   logic        dv_a, dv_b, dv_c;
   logic [15:0] re_a, re_b, re_c, im_a, im_b, im_c;
   logic [4:0]  sh_a, sh_b, sh_c;
   logic [7:0]  ex_a, ex_c;
   logic [2:0]  ex_b;

   bfp_shifter u_dut_a (
      .clk(clk), .rst(rst), .clr_exp(clr_exp), .bfp_load(bfp_load), .max_bw(max_bw),
      .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
      .dout_valid(dv_a), .dout_re(re_a), .dout_im(im_a), .shift(sh_a), .bfp_exp(ex_a)
   );

   bfp_shifter #(.FFT_EXPDW(3)) u_dut_b (
      .clk(clk), .rst(rst), .clr_exp(clr_exp), .bfp_load(bfp_load), .max_bw(max_bw),
      .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
      .dout_valid(dv_b), .dout_re(re_b), .dout_im(im_b), .shift(sh_b), .bfp_exp(ex_b)
   );

   bfp_shifter #(.FFT_TGTBW(0)) u_dut_c (
      .clk(clk), .rst(rst), .clr_exp(clr_exp), .bfp_load(bfp_load), .max_bw(max_bw),
      .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
      .dout_valid(dv_c), .dout_re(re_c), .dout_im(im_c), .shift(sh_c), .bfp_exp(ex_c)
   );

   always #5 clk = ~clk;

   logic signed [31:0] o_v [NI];
   logic signed [31:0] o_re [NI];
   logic signed [31:0] o_im [NI];
   logic signed [31:0] o_sh [NI];
   logic signed [31:0] o_ex [NI];

   always_comb begin
      o_v[0]  = {31'b0, dv_a};
      o_v[1]  = {31'b0, dv_b};
      o_v[2]  = {31'b0, dv_c};
      o_re[0] = 32'($signed(re_a));
      o_re[1] = 32'($signed(re_b));
      o_re[2] = 32'($signed(re_c));
      o_im[0] = 32'($signed(im_a));
      o_im[1] = 32'($signed(im_b));
      o_im[2] = 32'($signed(im_c));
      o_sh[0] = {27'b0, sh_a};
      o_sh[1] = {27'b0, sh_b};
      o_sh[2] = {27'b0, sh_c};
      o_ex[0] = {24'b0, ex_a};
      o_ex[1] = {29'b0, ex_b};
      o_ex[2] = {24'b0, ex_c};
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int tgt_of(input int k);
      return (k == 2) ? 0 : 15;
   endfunction

   function automatic int expw_of(input int k);
      return (k == 1) ? 3 : 8;
   endfunction

   // x / 2^s rounded half toward +inf, as floor((x + 2^(s-1)) / 2^s).
   function automatic int rnd(input int x, input int s);
      if (s == 0) return x;
      return (x + (1 << (s - 1))) >>> s;
   endfunction

   int m_v, p_v;
   int m_re [NI];
   int m_im [NI];
   int p_re [NI];
   int p_im [NI];
   int m_shift [NI];
   int m_exp [NI];

   task automatic step();
      int sn, base, lim;
      @(posedge clk);
      if (!rst) begin
         m_v = 0;
         p_v = 0;
         for (int k = 0; k < NI; k++) begin
            m_re[k] = 0; m_im[k] = 0; p_re[k] = 0; p_im[k] = 0;
            m_shift[k] = 0; m_exp[k] = 0;
         end
      end else begin
         m_v = p_v;
         for (int k = 0; k < NI; k++) begin
            if (p_v != 0) begin
               m_re[k] = p_re[k];
               m_im[k] = p_im[k];
            end
         end
         p_v = int'(din_valid);
         for (int k = 0; k < NI; k++) begin
            if (din_valid) begin
               p_re[k] = rnd(int'($signed(din_re)), m_shift[k]);
               p_im[k] = rnd(int'($signed(din_im)), m_shift[k]);
            end
            sn = int'(max_bw) - tgt_of(k);
            if (sn < 0) sn = 0;
            if (sn > 15) sn = 15;
            lim = (1 << expw_of(k)) - 1;
            if (bfp_load) begin
               base = clr_exp ? 0 : m_exp[k];
               m_exp[k] = (base + sn > lim) ? lim : base + sn;
               m_shift[k] = sn;
            end else if (clr_exp) begin
               m_shift[k] = 0;
               m_exp[k] = 0;
            end
         end
      end
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("i%0d_valid", k), o_v[k], m_v);
         check($sformatf("i%0d_re", k), o_re[k], m_re[k]);
         check($sformatf("i%0d_im", k), o_im[k], m_im[k]);
         check($sformatf("i%0d_shift", k), o_sh[k], m_shift[k]);
         check($sformatf("i%0d_exp", k), o_ex[k], m_exp[k]);
      end
   endtask

   task automatic cyc_in(input bit ld, input int bw, input bit cl, input bit v, input int re, input int im);
      bfp_load  = ld;
      max_bw    = 5'(bw);
      clr_exp   = cl;
      din_valid = v;
      din_re    = 16'(re);
      din_im    = 16'(im);
      step();
   endtask

   function automatic int pick();
      case ($urandom_range(0, 9))
         0:       return 32767;
         1:       return -32768;
         default: return int'($signed(16'($urandom)));
      endcase
   endfunction

   initial begin
      m_v = 0;
      p_v = 0;
      for (int k = 0; k < NI; k++) begin
         m_re[k] = 0; m_im[k] = 0; p_re[k] = 0; p_im[k] = 0;
         m_shift[k] = 0; m_exp[k] = 0;
      end
      rst = 1'b0;
      repeat (3) cyc_in(0, 0, 0, 0, 0, 0);
      check("reset_valid", o_v[0], 0);
      check("reset_exp", o_ex[0], 0);
      rst = 1'b1;

      // passthrough
      cyc_in(1, 15, 0, 0, 0, 0);
      check("t2_shift", o_sh[0], 0);
      cyc_in(0, 0, 0, 1, 'h1234, 'hEDCC);
      cyc_in(0, 0, 0, 0, 0, 0);
      check("t2_valid", o_v[0], 1);
      check("t2_re", o_re[0], 4660);
      check("t2_im", o_im[0], -4660);

      // rounding
      cyc_in(1, 17, 0, 0, 0, 0);
      check("t3_shift", o_sh[0], 2);
      check("t3_exp", o_ex[0], 2);
      cyc_in(0, 0, 0, 1, 7, -6);
      cyc_in(0, 0, 0, 1, 'h7FFF, 'h8000);
      check("t3_re_7", o_re[0], 2);
      check("t3_im_m6", o_im[0], -1);
      cyc_in(0, 0, 0, 0, 0, 0);
      check("t3_re_max", o_re[0], 8192);
      check("t3_im_min", o_im[0], -8192);

      // load mid-stream with contiguous samples
      cyc_in(1, 15, 1, 0, 0, 0);
      cyc_in(0, 0, 0, 1, 5, 5);
      cyc_in(1, 16, 0, 1, 5, 5);
      cyc_in(0, 0, 0, 1, 5, 5);
      check("t4_old_shift", o_re[0], 5);
      cyc_in(0, 0, 0, 0, 0, 0);
      check("t4_new_valid", o_v[0], 1);
      check("t4_new_shift", o_re[0], 3);

      // exponent saturation on the 3-bit instance
      cyc_in(0, 0, 1, 0, 0, 0);
      cyc_in(1, 18, 0, 0, 0, 0);
      check("t5_exp_3", o_ex[1], 3);
      cyc_in(1, 18, 0, 0, 0, 0);
      check("t5_exp_6", o_ex[1], 6);
      cyc_in(1, 18, 0, 0, 0, 0);
      check("t5_exp_sat", o_ex[1], 7);
      cyc_in(1, 16, 1, 0, 0, 0);
      check("t5_clr_load", o_ex[1], 1);

      // clamp on the zero-target instance
      cyc_in(1, 31, 0, 0, 0, 0);
      check("t6_shift", o_sh[2], 15);
      cyc_in(0, 0, 0, 1, -1, 'h4000);
      cyc_in(0, 0, 0, 0, 0, 0);
      check("t6_re", o_re[2], 0);
      check("t6_im", o_im[2], 1);

      for (int i = 0; i < 1500; i++) begin
         cyc_in($urandom_range(0, 7) == 0, int'($urandom_range(0, 31)), $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0, pick(), pick());
      end

      // asynchronous reset in the middle of a stream
      cyc_in(1, 20, 0, 1, 1000, -1000);
      cyc_in(0, 0, 0, 1, 2000, -2000);
      #2 rst = 1'b0;
      cyc_in(0, 0, 0, 1, 3000, -3000);
      check("t1_valid", o_v[0], 0);
      check("t1_re", o_re[0], 0);
      check("t1_shift", o_sh[0], 0);
      check("t1_exp", o_ex[0], 0);
      rst = 1'b1;
      cyc_in(0, 0, 0, 0, 0, 0);
      cyc_in(0, 0, 0, 0, 0, 0);
      check("t1_no_stale", o_v[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
